ao6p_stim_checker: RTL and testbench

Sequential stimulus driver and response checker for the lsi_10k AO6P cell (Z = !((A & B) | C)). It drives the cell's A/B/C inputs through all eight input combinations and samples the cell's Z output after a programmable settle time. It compares each sample against the expected AND-NOR value and reports per-vector failures and a saturating error count. It sits beside an AO6P instance in gate-level characterisation and test-chip benches, as the driving and observing end of the cell's pins.

---
 rtl/ao6p_chk_pkg.sv | 27 ++
 rtl/ao6p_chk_sync.sv | 30 +++
 rtl/ao6p_stim_checker.sv | 144 ++++++++++++++
 tb/tb_ao6p_stim_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ao6p_chk_pkg.sv
// ao6p_chk_pkg
// Shared types and helpers for the AO6P stimulus/response checker.
//   state_t  : checker FSM states
//   VEC_W    : width of the A/B/C vector index
//   ERR_W    : width of the saturating mismatch counter
//   NUM_VEC  : number of input combinations swept per pass
//   ao6p_exp : expected Z of a healthy AO6P cell for a given vector
package ao6p_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    localparam int VEC_W   = 3;
    localparam int ERR_W   = 8;
    localparam int NUM_VEC = 8;

    // Vector bit order is {A, B, C}; Z = !((A & B) | C).
    function automatic logic ao6p_exp(input logic [VEC_W-1:0] vec);
        return ~((vec[2] & vec[1]) | vec[0]);
    endfunction

endpackage

// File: rtl/ao6p_chk_sync.sv
// ao6p_chk_sync
// Two-flop synchronizer for the Z pin of the cell under test.
// Ports:
//   CP : clock, rising edge
//   CD : asynchronous active-low reset, clears both flops
//   d  : asynchronous input
//   q  : synchronized output (two CP edges of latency)
module ao6p_chk_sync (
    input  logic CP,
    input  logic CD,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/ao6p_stim_checker.sv
// ao6p_stim_checker
// Drives an AO6P cell through all eight A/B/C combinations, samples Z after
// a programmable settle time and compares it with the expected AND-NOR value.
// Build option: define AO6P_CHK_ZSYNC_EN to pass Z through a two-flop
// synchronizer; the settle phase is then stretched by two cycles.
// Parameters:
//   SETTLE_CYCLES : cycles between applying a vector and sampling Z (1..255)
//   PASSES        : full 8-vector sweeps per run (1..15)
// Ports:
//   CP, CD        : clock (rising edge), asynchronous active-low reset
//   START         : run request, only honoured while idle
//   Z             : output of the cell under test
//   A, B, C       : registered stimulus to the cell
//   BUSY          : run in progress
//   DONE          : one-cycle end-of-run pulse
//   PASS          : last run had no mismatches (held until next START)
//   ERR_CNT       : saturating mismatch count
//   FAIL_VEC      : sticky per-vector mismatch flags
module ao6p_stim_checker
    import ao6p_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int PASSES        = 1
) (
    input  logic       CP,
    input  logic       CD,
    input  logic       START,
    input  logic       Z,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] ERR_CNT,
    output logic [7:0] FAIL_VEC
);

`ifdef AO6P_CHK_ZSYNC_EN
    localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif

    localparam logic [8:0]       SETTLE_LAST = 9'(SETTLE_LEN - 1);
    localparam logic [3:0]       PASS_LAST   = 4'(PASSES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [3:0]       pass_cnt;
    logic [8:0]       settle_cnt;
    logic             z_cmp;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

`ifdef AO6P_CHK_ZSYNC_EN
    ao6p_chk_sync u_zsync (
        .CP (CP),
        .CD (CD),
        .d  (Z),
        .q  (z_cmp)
    );
`else
    assign z_cmp = Z;
`endif

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state      <= IDLE;
            A          <= 1'b0;
            B          <= 1'b0;
            C          <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VEC   <= '0;
            vec        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    {A, B, C} <= 3'b000;
                    DONE      <= 1'b0;
                    if (START) begin
                        ERR_CNT  <= '0;
                        FAIL_VEC <= '0;
                        PASS     <= 1'b0;
                        vec      <= '0;
                        pass_cnt <= '0;
                        BUSY     <= 1'b1;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    {A, B, C}  <= vec;
                    settle_cnt <= SETTLE_LAST;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    // Counter runs SETTLE_LAST..0, i.e. SETTLE_LEN cycles.
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (z_cmp != ao6p_exp(vec)) begin
                        ERR_CNT       <= sat_inc(ERR_CNT);
                        FAIL_VEC[vec] <= 1'b1;
                    end
                    if (vec != VEC_LAST) begin
                        vec   <= vec + 1'b1;
                        state <= APPLY;
                    end else if (pass_cnt != PASS_LAST) begin
                        pass_cnt <= pass_cnt + 1'b1;
                        vec      <= '0;
                        state    <= APPLY;
                    end else begin
                        // Stimulus drops to 0 for the FINISH cycle itself.
                        {A, B, C} <= 3'b000;
                        DONE      <= 1'b1;
                        state     <= FINISH;
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    PASS  <= (ERR_CNT == '0);
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ao6p_stim_checker.sv
module tb_ao6p_stim_checker;

    localparam int S = 4;
    localparam int P = 1;
`ifdef AO6P_CHK_ZSYNC_EN
    localparam int VT      = S + 4;
    localparam int LIT_L1  = 64;
    localparam int LIT_L2  = 128;
`else
    localparam int VT      = S + 2;
    localparam int LIT_L1  = 48;
    localparam int LIT_L2  = 96;
`endif
    localparam int L = 8 * P * VT;

    logic       CP = 1'b0;
    logic       CD = 1'b0;
    logic       START = 1'b0;
    logic       Z;
    logic       A, B, C, BUSY, DONE, PASS;
    logic [7:0] ERR_CNT, FAIL_VEC;

    logic       A2, B2, C2, BUSY2, DONE2, PASS2;
    logic [7:0] ERR2, FV2;

    int         mode  = 0;
    logic [7:0] flip  = 8'h00;
    logic       zrand = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 CP = ~CP;

    function automatic logic exp_z(input int v);
        logic [2:0] vv;
        vv = v[2:0];
        return ~((vv[2] & vv[1]) | vv[0]);
    endfunction

    // Cell under test: good, stuck-at-0, stuck-at-1, per-vector corruption, free-running.
    function automatic logic cell_z(input int m, input logic [2:0] v,
                                    input logic [7:0] fl, input logic zr);
        case (m)
            0:       return exp_z(int'(v));
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return exp_z(int'(v)) ^ fl[v];
            default: return zr;
        endcase
    endfunction

    assign Z = cell_z(mode, {A, B, C}, flip, zrand);

    ao6p_stim_checker #(.SETTLE_CYCLES(S), .PASSES(P)) dut (
        .CP(CP), .CD(CD), .START(START), .Z(Z),
        .A(A), .B(B), .C(C), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .ERR_CNT(ERR_CNT), .FAIL_VEC(FAIL_VEC)
    );

    ao6p_stim_checker #(.SETTLE_CYCLES(S), .PASSES(2)) dut2 (
        .CP(CP), .CD(CD), .START(START), .Z(1'b1),
        .A(A2), .B(B2), .C(C2), .BUSY(BUSY2), .DONE(DONE2), .PASS(PASS2),
        .ERR_CNT(ERR2), .FAIL_VEC(FV2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: k counts edges since the edge that accepted START.
    // Vector j is judged on edge (j+1)*VT; FINISH follows edge L.
    bit         m_idle = 1'b1;
    int         k      = 0;
    int         m_err  = 0;
    logic [7:0] m_fv   = 8'h00;
    bit         m_pass = 1'b0;

    always @(posedge CP or negedge CD) begin
        int j;
        if (!CD) begin
            m_idle = 1'b1; k = 0; m_err = 0; m_fv = 8'h00; m_pass = 1'b0;
        end else if (m_idle) begin
            if (START) begin
                m_idle = 1'b0; k = 0; m_err = 0; m_fv = 8'h00; m_pass = 1'b0;
            end
        end else begin
            k++;
            if (k <= L && (k % VT) == 0) begin
                j = (k / VT - 1) % 8;
                if (cell_z(mode, j[2:0], flip, zrand) != exp_z(j)) begin
                    if (m_err < 255) m_err++;
                    m_fv[j[2:0]] = 1'b1;
                end
            end
            if (k == L + 1) begin
                m_idle = 1'b1;
                m_pass = (m_err == 0);
            end
        end
    end

    always @(negedge CP) begin
        int ev;
        if (m_idle || k == 0 || k == L) ev = 0;
        else ev = ((k - 1) / VT) % 8;
        check("abc",      {29'd0, A, B, C}, ev);
        check("busy",     BUSY, !m_idle);
        check("done",     DONE, (!m_idle && k == L));
        check("pass",     PASS, m_pass);
        check("err_cnt",  ERR_CNT, m_err);
        check("fail_vec", FAIL_VEC, m_fv);
    end

    // Pulse START, then count edges until each DUT reports DONE.
    task automatic run_both(output int e1, output int e2);
        int n;
        @(negedge CP); START = 1'b1;
        @(posedge CP);
        @(negedge CP); START = 1'b0;
        n = 0; e1 = -1; e2 = -1;
        while ((e1 < 0 || e2 < 0) && n < 400) begin
            @(posedge CP); n++;
            @(negedge CP);
            if (DONE  && e1 < 0) e1 = n;
            if (DONE2 && e2 < 0) e2 = n;
        end
        @(negedge CP);
    endtask

    initial begin
        int e1, e2, n, hold;

        // Reset held while inputs toggle.
        mode = 4;
        repeat (8) begin
            @(negedge CP);
            START = 1'($urandom);
            zrand = 1'($urandom);
        end
        check("reset_outs", {A, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC}, 0);
        START = 1'b0; mode = 0;
        @(negedge CP); #2 CD = 1'b1;
        repeat (2) @(negedge CP);

        // Good cell; dut2 sees Z stuck at 1 with two passes.
        mode = 0;
        run_both(e1, e2);
        check("good_done_edge", e1, LIT_L1);
        check("good_pass",      PASS, 1);
        check("good_err",       ERR_CNT, 0);
        check("good_fv",        FAIL_VEC, 8'h00);
        check("s1x2_done_edge", e2, LIT_L2);
        check("s1x2_fv",        FV2, 8'hEA);
        check("s1x2_err",       ERR2, 10);
        check("s1x2_pass",      PASS2, 0);

        // Stuck-at-0.
        mode = 1;
        run_both(e1, e2);
        check("s0_fv",   FAIL_VEC, 8'h15);
        check("s0_err",  ERR_CNT, 3);
        check("s0_pass", PASS, 0);

        // Stuck-at-1, single pass.
        mode = 2;
        run_both(e1, e2);
        check("s1_fv",  FAIL_VEC, 8'hEA);
        check("s1_err", ERR_CNT, 5);

        // Abort: spurious START mid-run, then reset while vector 3 is applied.
        mode = 0;
        @(negedge CP); START = 1'b1;
        @(negedge CP); START = 1'b0;
        repeat (5) @(negedge CP);
        START = 1'b1;
        @(negedge CP); START = 1'b0;
        n = 0;
        while (k != 3 * VT + 2 && n < 200) begin @(negedge CP); n++; end
        check("abort_reached", n < 200, 1);
        check("abort_vec3", {A, B, C}, 3'd3);
        #2 CD = 1'b0;
        #1 check("abort_outs", {A, B, C, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC}, 0);
        repeat (3) @(negedge CP);
        #2 CD = 1'b1;
        run_both(e1, e2);
        check("restart_done_edge", e1, LIT_L1);
        check("restart_pass",      PASS, 1);

        // Randomized runs: random faults, START holds (re-arm), occasional resets.
        for (int r = 0; r < 8; r++) begin
            mode = $urandom_range(0, 3);
            flip = 8'($urandom);
            hold = $urandom_range(1, 70);
            @(negedge CP); START = 1'b1;
            repeat (hold) @(negedge CP);
            START = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 30)) @(negedge CP);
                #2 CD = 1'b0;
                @(negedge CP);
                #2 CD = 1'b1;
            end
            n = 0;
            while (!m_idle && n < 300) begin @(negedge CP); n++; end
            check("rand_idle", m_idle, 1);
            repeat (2) @(negedge CP);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
